prog_rom: RTL
=============

PROG_ROM -- requirements
Module: prog_rom

Interface
REQ-001 SHALL have parameter DATA_W, default 32: word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 10: address width in bits.
REQ-003 SHALL have parameter DEPTH, default 1024: word count, 2 <= DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter RD_LAT, default 1: read latency in cycles, legal values 1 or 2.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clka in 1, rising-edge clock; rsta in 1, asynchronous active-high reset.
REQ-006 SHALL have ld_start in 1: a pulse that begins or restarts a load.
REQ-007 SHALL have ld_valid in 1: load word present on ld_data.
REQ-008 SHALL have ld_data in DATA_W: the load word.
REQ-009 SHALL have ld_ready out 1: high when a load word is accepted this cycle.
REQ-010 SHALL have ld_done out 1: a one-cycle pulse when the last word is written.
REQ-011 SHALL have ld_cnt out ADDR_W+1: the count of words written in the current load.
REQ-012 SHALL have rd_en in 1: read request.
REQ-013 SHALL have addra in ADDR_W: read address.
REQ-014 SHALL have douta out DATA_W: read data.
REQ-015 SHALL have rd_valid out 1: douta carries the data of a completed read.
REQ-016 SHALL have rd_err out 1: a one-cycle pulse when a read request is rejected.
REQ-017 SHALL have rom_rdy out 1: high while the state is READY.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, READY, with storage mem[0:DEPTH-1] of DATA_W bits.
REQ-019 SHALL make these transitions on ld_start=1:
- IDLE->LOAD
- READY->LOAD
- LOAD->LOAD, clearing ld_cnt to 0 next cycle.
REQ-020 SHALL drive ld_ready=1 combinationally exactly when state=LOAD and ld_start=0.
REQ-021 SHALL accept a word when ld_valid & ld_ready: mem[ld_cnt] <= ld_data, ld_cnt increments by 1.
REQ-022 SHALL go LOAD->READY on accepting the word at ld_cnt=DEPTH-1, pulse ld_done the next cycle (aligned with rom_rdy rising), and leave ld_cnt=DEPTH.
REQ-023 SHALL, when ld_start and ld_valid are high in the same cycle, let ld_start win: data discarded, no write.
REQ-024 SHALL ignore ld_valid in IDLE and READY (no write, ld_cnt unchanged).
REQ-025 SHALL treat a read as accepted when rd_en=1, state=READY and addra<DEPTH.
REQ-026 SHALL produce douta=mem[addra] with rd_valid=1 exactly RD_LAT cycles after an accepted read; back-to-back reads give one result per cycle.
REQ-027 SHALL hold douta at its last value and drive rd_valid=0 in any cycle with no result.
REQ-028 SHALL reject a read when rd_en=1 and (state!=READY or addra>=DEPTH): rd_err=1 in the next cycle, no rd_valid, douta unchanged.
REQ-029 SHALL complete reads accepted in READY with the old contents even if ld_start arrives while they are in flight.
REQ-030 SHALL register all outputs except ld_ready.
REQ-031 SHALL, for RD_LAT=2, add an output register stage after the memory read register.

Reset
REQ-032 SHALL, on rsta=1, immediately set: state=IDLE, ld_cnt=0, ld_done=0, rd_valid=0, rd_err=0, douta=0, rom_rdy=0, all pipeline valid bits 0.
REQ-033 SHALL leave mem contents unchanged by reset; reset mid-load abandons the load, and a full new load is required before reads are accepted.
REQ-034 SHALL have no effect from inputs while rsta=1.

Verification
REQ-035 SHALL cover: DEPTH=4 load of 0x11,0x22,0x33,0x44 with ld_valid held -> ld_ready high 4 cycles, ld_done pulses once, ld_cnt=4, rom_rdy=1.
REQ-036 SHALL cover: RD_LAT=1, reads addr 3,0,2 back-to-back -> douta 0x44,0x11,0x33 with rd_valid high 3 consecutive cycles starting 1 cycle after the first rd_en; RD_LAT=2 -> same data starting 2 cycles after.
REQ-037 SHALL cover: rd_en during LOAD, or addra=5 with DEPTH=4 -> rd_err pulse 1 cycle, rd_valid=0, douta unchanged.
REQ-038 SHALL cover: load stalled (ld_valid toggling 1,0,1) -> writes occur only on ld_valid cycles, ld_cnt steps 0,1,1,2.
REQ-039 SHALL cover: ld_start with ld_valid=1 at ld_cnt=2 -> no write, ld_cnt=0 next cycle, a later full load makes mem the new contents.
REQ-040 SHALL cover: rsta asserted asynchronously mid-load at ld_cnt=2 -> outputs at reset values before the next clka edge, state IDLE, rd_en rejected with rd_err.

Source files
------------

// File: rtl/prog_rom_if.sv
// prog_rom_if: load and read bus of the program ROM.
//   ld_start/ld_valid/ld_data : load control and data (master -> rom)
//   ld_ready/ld_done/ld_cnt   : load handshake and progress (rom -> master)
//   rd_en/addra               : read request (master -> rom)
//   douta/rd_valid/rd_err     : read result and rejection pulse (rom -> master)
//   rom_rdy                   : contents valid and reads accepted (rom -> master)
interface prog_rom_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
);
    logic              ld_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              ld_done;
    logic [ADDR_W:0]   ld_cnt;
    logic              rd_en;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] douta;
    logic              rd_valid;
    logic              rd_err;
    logic              rom_rdy;

    modport master (
        output ld_start, ld_valid, ld_data, rd_en, addra,
        input  ld_ready, ld_done, ld_cnt, douta, rd_valid, rd_err, rom_rdy
    );

    modport slave (
        input  ld_start, ld_valid, ld_data, rd_en, addra,
        output ld_ready, ld_done, ld_cnt, douta, rd_valid, rd_err, rom_rdy
    );
endinterface

// File: rtl/prog_rom.sv
// prog_rom: loadable program ROM. A load (started by ld_start) streams DEPTH words
// into mem; once complete the ROM serves reads with RD_LAT (1 or 2) cycles latency.
//   clka : rising-edge clock
//   rsta : asynchronous active-high reset (mem contents are not cleared)
//   bus  : prog_rom_if slave modport (load and read channels)
module prog_rom #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clka,
    input  logic          rsta,
    prog_rom_if.slave     bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] READY = 2'd2;

    localparam int unsigned     IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_CNT  = (ADDR_W + 1)'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   ld_cnt_q, ld_cnt_d;
    logic              ld_done_q, ld_done_d;
    logic              rom_rdy_q, rom_rdy_d;
    logic              rd_err_q, rd_err_d;
    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic              wr_en;
    logic              rd_acc;

    always_comb begin
        // ld_start wins over a coincident ld_valid: the word is dropped.
        wr_en  = (state_q == LOAD) && !bus.ld_start && bus.ld_valid;
        rd_acc = bus.rd_en && (state_q == READY) && ({1'b0, bus.addra} < DEPTH_CNT);

        state_d   = state_q;
        ld_cnt_d  = ld_cnt_q;
        ld_done_d = 1'b0;
        if (bus.ld_start) begin
            state_d  = LOAD;
            ld_cnt_d = '0;
        end else if (wr_en) begin
            ld_cnt_d = ld_cnt_q + 1'b1;
            if (ld_cnt_q == LAST_CNT) begin
                state_d   = READY;
                ld_done_d = 1'b1;
            end
        end
        rom_rdy_d = (state_d == READY);
        rd_err_d  = bus.rd_en && !rd_acc;

        // The read register captures at acceptance, so a load started right after
        // cannot disturb reads already in flight; it holds when no read is accepted.
        s1_valid_d = rd_acc;
        s1_data_d  = rd_acc ? mem[bus.addra[IDX_W-1:0]] : s1_data_q;
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state_q    <= IDLE;
            ld_cnt_q   <= '0;
            ld_done_q  <= 1'b0;
            rom_rdy_q  <= 1'b0;
            rd_err_q   <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            ld_done_q  <= ld_done_d;
            rom_rdy_q  <= rom_rdy_d;
            rd_err_q   <= rd_err_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
        end
    end

    // Storage has no reset; writes are only possible in LOAD, which reset leaves.
    always_ff @(posedge clka) begin
        if (wr_en) begin
            mem[ld_cnt_q[IDX_W-1:0]] <= bus.ld_data;
        end
    end

    assign bus.ld_ready = (state_q == LOAD) && !bus.ld_start;
    assign bus.ld_done  = ld_done_q;
    assign bus.ld_cnt   = ld_cnt_q;
    assign bus.rom_rdy  = rom_rdy_q;
    assign bus.rd_err   = rd_err_q;

    if (RD_LAT == 2) begin : g_lat2
        logic              s2_valid_q, s2_valid_d;
        logic [DATA_W-1:0] s2_data_q, s2_data_d;

        always_comb begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
        end

        always_ff @(posedge clka or posedge rsta) begin
            if (rsta) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s2_valid_d;
                s2_data_q  <= s2_data_d;
            end
        end

        assign bus.douta    = s2_data_q;
        assign bus.rd_valid = s2_valid_q;
    end else begin : g_lat1
        assign bus.douta    = s1_data_q;
        assign bus.rd_valid = s1_valid_q;
    end
endmodule
